// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a shared synchronous FIFO, with bounded burst locking.
// A producer that wins may keep the port for up to MAX_BURST consecutive words.

module fifo_wr_arbiter_lane #(
    parameter int DATA_W = 8
) (
    input  logic              sel,
    input  logic              xfer,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic [DATA_W-1:0] data_out
);
    assign ready    = sel & xfer;
    assign data_out = ready ? data : '0;
endmodule

module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_enable,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*DATA_W-1:0]  i_req_data,
    output logic [N_REQ-1:0]         o_req_ready,
    input  logic                     i_fifo_full,
    output logic                     o_fifo_wr_en,
    output logic [DATA_W-1:0]        o_fifo_data,
    output logic [$clog2(N_REQ)-1:0] o_grant_id,
    output logic                     o_busy
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {ARB, LOCK} state_t;

    state_t                         state, state_nx;
    logic [ID_W-1:0]                owner, owner_nx;
    logic [ID_W-1:0]                last_id, last_id_nx;
    logic [ID_W-1:0]                grant_id, grant_id_nx;
    logic [CNT_W-1:0]               burst_cnt, burst_cnt_nx;

    logic [N_REQ-1:0][DATA_W-1:0]   req_data;
    logic [N_REQ-1:0][DATA_W-1:0]   lane_data;
    logic [N_REQ-1:0]               lane_ready;
    logic [ID_W-1:0]                winner;
    logic [ID_W-1:0]                cand;
    logic                           found;
    logic                           any_valid;
    logic                           xfer;
    logic [CNT_W-1:0]               count;

    assign req_data  = i_req_data;
    assign any_valid = |i_req_valid;

    // Locked owner keeps the port while valid; otherwise rotate from the last writer.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        if (state == LOCK && i_req_valid[owner]) begin
            winner = owner;
            found  = 1'b1;
        end else begin
            for (int off = 1; off <= N_REQ; off++) begin
                cand = ID_W'((int'(last_id) + off) % N_REQ);
                if (!found && i_req_valid[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end
    end

    // rst_n in the product forces every combinational output low during reset.
    assign xfer = rst_n & i_enable & ~i_fifo_full & any_valid & i_req_valid[winner];

    genvar k;
    generate
        for (k = 0; k < N_REQ; k++) begin : g_lane
            fifo_wr_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
                .sel      (winner == ID_W'(k)),
                .xfer     (xfer),
                .data     (req_data[k]),
                .ready    (lane_ready[k]),
                .data_out (lane_data[k])
            );
        end
    endgenerate

    always_comb begin
        o_fifo_data = '0;
        for (int i = 0; i < N_REQ; i++) o_fifo_data = o_fifo_data | lane_data[i];
    end

    assign o_req_ready  = lane_ready;
    assign o_fifo_wr_en = xfer;
    assign o_grant_id   = grant_id;
    assign o_busy       = (state == LOCK);

    assign count = (state == LOCK && winner == owner) ? burst_cnt + 1'b1 : CNT_W'(1);

    always_comb begin
        state_nx     = state;
        owner_nx     = owner;
        last_id_nx   = last_id;
        grant_id_nx  = grant_id;
        burst_cnt_nx = burst_cnt;
        if (!i_enable) begin
            state_nx     = ARB;
            burst_cnt_nx = '0;
        end else if (i_fifo_full) begin
            // Everything frozen so the locked owner resumes first.
        end else if (xfer) begin
            last_id_nx  = winner;
            grant_id_nx = winner;
            owner_nx    = winner;
            if (count == CNT_W'(MAX_BURST)) begin
                state_nx     = ARB;
                burst_cnt_nx = '0;
            end else begin
                state_nx     = LOCK;
                burst_cnt_nx = count;
            end
        end else begin
            state_nx     = ARB;
            burst_cnt_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            owner     <= '0;
            last_id   <= ID_W'(N_REQ - 1);
            grant_id  <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            last_id   <= last_id_nx;
            grant_id  <= grant_id_nx;
            burst_cnt <= burst_cnt_nx;
        end
    end
endmodule
